// File: rtl/cdm16_mem_responder_if.sv
// Bus bundle between the cdm16 core (master) and the memory responder (slave).
// The fault outputs feed the core's external-exception inputs.
interface cdm16_mem_responder_if;
  logic [15:0] address;
  logic        mem;
  logic        data;
  logic        read;
  logic        word;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        hold;
  logic        bus_err;
  logic [5:0]  err_vec;

  modport master (
    output address, mem, data, read, word, data_out,
    input  data_in, hold, bus_err, err_vec
  );

  modport slave (
    input  address, mem, data, read, word, data_out,
    output data_in, hold, bus_err, err_vec
  );
endinterface

// File: rtl/cdm16_mem_responder.sv
// Memory-side responder for the cdm16 bus: byte-addressed IMEM/DMEM with wait states,
// hold-based cycle stretching and a one-cycle bus fault pulse.
module cdm16_mem_responder #(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned WAIT_STATES     = 1,
  parameter bit          SPLIT_SPACES    = 1'b1,
  parameter bit          WRITE_PROTECT_I = 1'b1,
  parameter logic [5:0]  ERR_VEC         = 6'd5
) (
  input logic                  clk,
  input logic                  rst_n,
  cdm16_mem_responder_if.slave bus
);

  localparam int unsigned Bytes   = 1 << ADDR_W;
  localparam logic [3:0]  RdCount = 4'(WAIT_STATES);
  localparam logic [3:0]  WrCount = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [3:0]          count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                space_q;
  logic                read_q;
  logic                word_q;
  logic                err_q;
  logic [15:0]         wdata_q;
  logic [15:0]         data_in_q;
  logic                bus_err_q;

  logic [7:0]          imem [Bytes];
  logic [7:0]          dmem [Bytes];

  // Request decode on the live bus (meaningful in StIdle only)
  logic                out_of_range;
  logic                wp_fault;
  logic                err_now;
  logic                space_now;
  logic [3:0]          busy_cnt;
  logic                zero_wait_write;

  assign out_of_range    = (({16'h0000, bus.address} >> ADDR_W) != 32'h0);
  assign wp_fault        = WRITE_PROTECT_I && SPLIT_SPACES && !bus.data && !bus.read;
  assign err_now         = (bus.word & bus.address[0]) | out_of_range | wp_fault;
  assign space_now       = SPLIT_SPACES ? bus.data : 1'b1;
  assign busy_cnt        = bus.read ? RdCount : WrCount;
  assign zero_wait_write = (WAIT_STATES == 0) && !bus.read && !err_now;

  // The access is performed either straight from the bus in StIdle or from the
  // captured request at the end of StBusy; both paths share one datapath.
  logic                in_busy;
  logic                perform;
  logic [ADDR_W-1:0]   acc_addr;
  logic [ADDR_W-1:0]   acc_addr_hi;
  logic                acc_space;
  logic                acc_read;
  logic                acc_word;
  logic                acc_err;
  logic [15:0]         acc_wdata;
  logic                mem_we;

  always_comb begin
    in_busy     = (state_q == StBusy);
    acc_addr    = in_busy ? addr_q  : bus.address[ADDR_W-1:0];
    acc_space   = in_busy ? space_q : space_now;
    acc_read    = in_busy ? read_q  : bus.read;
    acc_word    = in_busy ? word_q  : bus.word;
    acc_err     = in_busy ? err_q   : err_now;
    acc_wdata   = in_busy ? wdata_q : bus.data_out;
    acc_addr_hi = {acc_addr[ADDR_W-1:1], 1'b1};
    perform     = ((state_q == StIdle) && bus.mem && (busy_cnt == 4'd0)) ||
                  (in_busy && (count_q == 4'd0));
    // rst_n gating drops a write whose edge coincides with reset
    mem_we      = rst_n && perform && !acc_read && !acc_err;
  end

  logic [7:0]  rd_lo;
  logic [7:0]  rd_hi;
  logic [15:0] rd_result;

  always_comb begin
    rd_lo     = acc_space ? dmem[acc_addr]    : imem[acc_addr];
    rd_hi     = acc_space ? dmem[acc_addr_hi] : imem[acc_addr_hi];
    rd_result = 16'h0000;
    if (!acc_err) begin
      rd_result = acc_word ? {rd_hi, rd_lo} : {8'h00, rd_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (acc_space) begin
        dmem[acc_addr] <= acc_wdata[7:0];
        if (acc_word) begin
          dmem[acc_addr_hi] <= acc_wdata[15:8];
        end
      end else begin
        imem[acc_addr] <= acc_wdata[7:0];
        if (acc_word) begin
          imem[acc_addr_hi] <= acc_wdata[15:8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= 4'd0;
      addr_q    <= '0;
      space_q   <= 1'b0;
      read_q    <= 1'b0;
      word_q    <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= 16'h0000;
      data_in_q <= 16'h0000;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.mem) begin
            addr_q  <= bus.address[ADDR_W-1:0];
            space_q <= space_now;
            read_q  <= bus.read;
            word_q  <= bus.word;
            err_q   <= err_now;
            wdata_q <= bus.data_out;
            if (busy_cnt == 4'd0) begin
              if (bus.read) begin
                data_in_q <= rd_result;
              end
              if (!zero_wait_write) begin
                state_q   <= StDone;
                bus_err_q <= err_now;
              end
            end else begin
              // Counter runs busy_cnt cycles in StBusy, performing on its last one
              count_q <= busy_cnt - 4'd1;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (count_q == 4'd0) begin
            if (read_q) begin
              data_in_q <= rd_result;
            end
            bus_err_q <= err_q;
            state_q   <= StDone;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  logic hold_c;

  always_comb begin
    hold_c = 1'b0;
    if (state_q == StIdle) begin
      hold_c = bus.mem & (bus.read | (WAIT_STATES != 0) | err_now);
    end else if (state_q == StBusy) begin
      hold_c = 1'b1;
    end
    hold_c = hold_c & rst_n;
  end

  assign bus.hold    = hold_c;
  assign bus.data_in = data_in_q;
  assign bus.bus_err = bus_err_q;
  assign bus.err_vec = ERR_VEC;

endmodule

// File: tb/tb_cdm16_mem_responder.sv
// Bench for cdm16_mem_responder: three instances (WAIT_STATES 1, 0, 3) share one stimulus bus
// and are checked against a byte-array model of the two memory spaces.
module tb_cdm16_mem_responder;

  function automatic int ws_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] address = 16'h0000;
  logic [15:0] data_out = 16'h0000;
  logic        mem = 1'b0;
  logic        data = 1'b0;
  logic        read = 1'b0;
  logic        word = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] din_a  [3];
  logic        hold_a [3];
  logic        berr_a [3];
  logic [5:0]  evec_a [3];

  cdm16_mem_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].address  = address;
    assign bus[g].mem      = mem && (sel == 2'(g));
    assign bus[g].data     = data;
    assign bus[g].read     = read;
    assign bus[g].word     = word;
    assign bus[g].data_out = data_out;
    assign din_a[g]        = bus[g].data_in;
    assign hold_a[g]       = bus[g].hold;
    assign berr_a[g]       = bus[g].bus_err;
    assign evec_a[g]       = bus[g].err_vec;

    cdm16_mem_responder #(
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus[g])
    );
  end

  logic [15:0] din_s;
  logic        hold_s;
  logic        berr_s;
  logic [5:0]  evec_s;

  always_comb begin
    din_s  = din_a[0];
    hold_s = hold_a[0];
    berr_s = berr_a[0];
    evec_s = evec_a[0];
    case (sel)
      2'd1: begin din_s = din_a[1]; hold_s = hold_a[1]; berr_s = berr_a[1]; evec_s = evec_a[1]; end
      2'd2: begin din_s = din_a[2]; hold_s = hold_a[2]; berr_s = berr_a[2]; evec_s = evec_a[2]; end
      default: ;
    endcase
  end

  // Reference model: per instance, per space, per byte
  logic [7:0]  mdl       [3][2][4096];
  bit          known     [3][2][4096];
  logic [15:0] last_din  [3];
  bit          din_known [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input int s, input logic [15:0] a, input logic d, input logic r,
                        input logic w, input logic [15:0] wd, input string tag,
                        output logic [15:0] got);
    int          ws;
    int          exp_hold;
    int          hcnt;
    logic        flt;
    logic        kn;
    logic        has_done;
    logic [11:0] ai;
    logic [15:0] rv;
    ws       = ws_of(s);
    flt      = (w && a[0]) || (a >= 16'h1000) || (!d && !r);
    exp_hold = r ? ws + 1 : ((ws == 0) ? (flt ? 1 : 0) : ws);
    has_done = !(ws == 0 && !r && !flt);
    ai       = a[11:0];
    rv       = w ? {mdl[s][d][ai + 12'd1], mdl[s][d][ai]} : {8'h00, mdl[s][d][ai]};
    kn       = known[s][d][ai] && (!w || known[s][d][ai + 12'd1]);

    sel      = 2'(s);
    address  = a;
    data     = d;
    read     = r;
    word     = w;
    data_out = wd;
    mem      = 1'b1;
    hcnt     = 0;
    got      = 16'h0000;
    @(negedge clk);
    while (hold_s && hcnt < 40) begin
      hcnt++;
      @(negedge clk);
    end
    if (has_done) begin
      got = din_s;
      if (r) begin
        if (flt || kn) begin
          check({tag, ":data"}, din_s, flt ? 16'h0000 : rv);
        end
        last_din[s]  = flt ? 16'h0000 : rv;
        din_known[s] = flt || kn;
      end else if (din_known[s]) begin
        check({tag, ":data_kept"}, din_s, last_din[s]);
      end
      check({tag, ":bus_err"}, {15'h0, berr_s}, {15'h0, flt});
      check({tag, ":err_vec"}, {10'h0, evec_s}, 16'h0005);
      mem = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      mem = 1'b0;
      got = din_s;
    end
    check({tag, ":hold"}, 16'(hcnt), 16'(exp_hold));

    if (!r && !flt) begin
      mdl[s][d][ai]   = wd[7:0];
      known[s][d][ai] = 1'b1;
      if (w) begin
        mdl[s][d][ai + 12'd1]   = wd[15:8];
        known[s][d][ai + 12'd1] = 1'b1;
      end
    end
  endtask

  logic [15:0] got;
  logic [15:0] imem_before;

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_din[i]  = 16'h0000;
      din_known[i] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset:hold", {15'h0, hold_a[i]}, 16'h0000);
      check("reset:data_in", din_a[i], 16'h0000);
      check("reset:bus_err", {15'h0, berr_a[i]}, 16'h0000);
      check("reset:err_vec", {10'h0, evec_a[i]}, 16'h0005);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: byte write then read back
    access(0, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h00A5, "ws1_wr", got);
    access(0, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, "ws1_rd", got);
    check("ws1_rd:value", got, 16'h00A5);

    // Zero wait states: word write, byte and word reads
    access(1, 16'h0020, 1'b1, 1'b0, 1'b1, 16'hBEEF, "ws0_wr", got);
    access(1, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h0000, "ws0_rd_lo", got);
    access(1, 16'h0021, 1'b1, 1'b1, 1'b0, 16'h0000, "ws0_rd_hi", got);
    access(1, 16'h0020, 1'b1, 1'b1, 1'b1, 16'h0000, "ws0_rd_w", got);
    check("ws0_rd_w:value", got, 16'hBEEF);

    // Misaligned word read, then a clean access
    access(0, 16'h0031, 1'b1, 1'b1, 1'b1, 16'h0000, "misalign", got);
    access(0, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, "after_fault", got);

    // IMEM write protection and space separation
    access(0, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000, "imem_rd0", imem_before);
    access(0, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0011, "imem_wr", got);
    access(0, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000, "imem_rd1", got);
    check("imem_unchanged_1", got, imem_before);
    access(0, 16'h0040, 1'b1, 1'b0, 1'b0, 16'h0022, "dmem_wr", got);
    access(0, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000, "imem_rd2", got);
    check("imem_unchanged_2", got, imem_before);
    access(0, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, "dmem_rd", got);

    // Out of range must fault and must not alias onto 0x000
    access(0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5A3C, "oor_pre", got);
    access(0, 16'h1000, 1'b1, 1'b1, 1'b1, 16'h0000, "oor_rd", got);
    access(0, 16'h1000, 1'b1, 1'b0, 1'b0, 16'h0077, "oor_wr_b", got);
    access(0, 16'h1000, 1'b1, 1'b0, 1'b1, 16'h9966, "oor_wr_w", got);
    access(0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, "oor_post", got);
    check("oor_post:value", got, 16'h5A3C);

    // Reset during BUSY of a word write drops the write
    access(2, 16'h0050, 1'b1, 1'b0, 1'b1, 16'h1234, "ws3_wr", got);
    access(2, 16'h0050, 1'b1, 1'b1, 1'b1, 16'h0000, "ws3_rd", got);
    sel      = 2'd2;
    address  = 16'h0050;
    data     = 1'b1;
    read     = 1'b0;
    word     = 1'b1;
    data_out = 16'hDEAD;
    mem      = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mem   = 1'b0;
    #1;
    check("rst_mid:hold", {15'h0, hold_a[2]}, 16'h0000);
    check("rst_mid:data_in", din_a[2], 16'h0000);
    check("rst_mid:bus_err", {15'h0, berr_a[2]}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      last_din[i]  = 16'h0000;
      din_known[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(2, 16'h0050, 1'b1, 1'b1, 1'b1, 16'h0000, "rst_after", got);
    check("rst_after:value", got, 16'h1234);

    // Randomized traffic on every instance
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) begin
        access(s, 16'h0100 + 16'(2 * k), 1'b1, 1'b0, 1'b1, 16'($urandom), "preload", got);
      end
      for (int i = 0; i < 40; i++) begin
        logic [15:0] a;
        logic        d;
        logic        r;
        logic        w;
        a = 16'h0100 + 16'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h1000, 16'hFFFF));
        d = ($urandom_range(0, 5) != 0);
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        access(s, a, d, r, w, 16'($urandom), "rand", got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
